// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : Writeback stage. Tracks rol32 two-step sequences through a
//             partial-result register and queues final results in a small
//             FIFO that feeds the coprocessor result handshake.
//  Option   : KRONOS_WB_RD0_SUPPRESS_EN - finals to rd=0 carry we=0, data=0.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          done_i,
    input  logic          continued_i,
    input  logic          result_reg_en_i,
    input  logic [DW-1:0] ex_data_i,
    input  logic [4:0]    rd_i,
    input  logic [3:0]    id_i,
    output logic [DW-1:0] partial_o,
    output logic          partial_valid_o,
    output logic          result_valid_o,
    input  logic          result_ready_i,
    output logic [DW-1:0] result_data_o,
    output logic [4:0]    result_rd_o,
    output logic [3:0]    result_id_o,
    output logic          result_we_o,
    output logic          stall_o,
    output logic          overflow_o,
    output logic          seq_err_o
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_ONE  = (AW+1)'(1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PARTIAL = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [DW-1:0] r_partial, w_partial_nxt;
    logic [3:0]    r_partial_id, w_partial_id_nxt;
    logic          r_seq_err, w_seq_err_nxt;
    logic          r_overflow;

    logic          w_inter;
    logic          w_final;

    assign w_inter = done_i & continued_i;
    assign w_final = done_i & ~continued_i;

    // ------------------------------------------------------------------------
    // Sequence tracker
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_partial    <= '0;
            r_partial_id <= '0;
            r_seq_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_partial    <= w_partial_nxt;
            r_partial_id <= w_partial_id_nxt;
            r_seq_err    <= w_seq_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_partial_nxt    = r_partial;
        w_partial_id_nxt = r_partial_id;
        w_seq_err_nxt    = r_seq_err;
        case (r_state)
            IDLE: begin
                if (w_inter && result_reg_en_i) begin
                    w_state_nxt      = PARTIAL;
                    w_partial_nxt    = ex_data_i;
                    w_partial_id_nxt = id_i;
                end
            end
            PARTIAL: begin
                if (w_inter) begin
                    // A second intermediate means the first was never consumed.
                    w_seq_err_nxt = 1'b1;
                    if (result_reg_en_i) begin
                        w_partial_nxt    = ex_data_i;
                        w_partial_id_nxt = id_i;
                    end
                end else if (w_final) begin
                    w_state_nxt      = IDLE;
                    w_partial_nxt    = '0;
                    w_partial_id_nxt = '0;
                    if (id_i != r_partial_id) begin
                        w_seq_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign partial_o       = r_partial;
    assign partial_valid_o = (r_state == PARTIAL);
    assign seq_err_o       = r_seq_err;

    // ------------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------------
    logic [DW-1:0] r_mem_data [DEPTH];
    logic [4:0]    r_mem_rd   [DEPTH];
    logic [3:0]    r_mem_id   [DEPTH];
    logic          r_mem_we   [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_push_we;
    logic [DW-1:0] w_push_data;

`ifdef KRONOS_WB_RD0_SUPPRESS_EN
    assign w_push_we   = (rd_i != 5'd0);
    assign w_push_data = w_push_we ? ex_data_i : '0;
`else
    assign w_push_we   = 1'b1;
    assign w_push_data = ex_data_i;
`endif

    assign w_full  = (r_count == c_FULL);
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & result_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_final & (~w_full | w_pop);
    assign w_drop  = w_final & w_full & ~w_pop;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_rd[r_wr_ptr]   <= rd_i;
            r_mem_id[r_wr_ptr]   <= id_i;
            r_mem_we[r_wr_ptr]   <= w_push_we;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Head fields are masked while empty so stale or unreset storage never leaks.
    assign result_valid_o = w_valid;
    assign result_data_o  = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign result_rd_o    = w_valid ? r_mem_rd[r_rd_ptr]   : '0;
    assign result_id_o    = w_valid ? r_mem_id[r_rd_ptr]   : '0;
    assign result_we_o    = w_valid & r_mem_we[r_rd_ptr];
    assign stall_o        = w_full;
    assign overflow_o     = r_overflow;

endmodule
`default_nettype wire
